// File: rtl/mem_io_unit_pkg.sv
// Shared encodings for the pP core memory/IO access stage.
package mem_io_unit_pkg;

  localparam logic [3:0] KIND_MEMIO = 4'b0011;

  localparam logic [1:0] FN_LOAD  = 2'b00;
  localparam logic [1:0] FN_STORE = 2'b01;
  localparam logic [1:0] FN_OUT   = 2'b10;
  localparam logic [1:0] FN_NOP   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_io_unit_bus_timeout_ctr.sv
// Saturating 8-bit wait counter; expired flags the last cycle allowed before abort.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic ck,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_io_unit.sv
// Memory/IO access stage: handshaked bus load/store, output port, timeout abort.
module mem_io_unit
  import mem_io_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input  logic       ck,
  input  logic       res,
  input  logic       ck2,
  input  logic [3:0] kind,
  input  logic [1:0] fn2,
  input  logic [7:0] addr,
  input  logic [7:0] store_d,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic [7:0] io_out,
  output logic [7:0] load_d,
  output logic       busy,
  output logic       err
);

  state_t     state_q, state_d;
  logic       bus_req_q, bus_req_d;
  logic       bus_we_q, bus_we_d;
  logic [7:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;
  logic [7:0] io_out_q, io_out_d;
  logic [7:0] load_d_q, load_d_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic launch;
  logic launch_bus;
  logic expired;

  assign launch     = (state_q == IDLE) && (kind == KIND_MEMIO) && ck2;
  assign launch_bus = launch && ((fn2 == FN_LOAD) || (fn2 == FN_STORE));

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .ck      (ck),
    .res     (res),
    .clear   (launch_bus),
    .enable  ((state_q == ACCESS) && !bus_ack),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    io_out_d    = io_out_q;
    load_d_d    = load_d_q;
    busy_d      = busy_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (launch_bus) begin
          bus_addr_d  = addr;
          bus_wdata_d = store_d;
          bus_we_d    = fn2[0];
          bus_req_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end else if (launch && (fn2 == FN_OUT)) begin
          io_out_d = store_d;
        end
      end
      ACCESS: begin
        // Ack is tested first so an ack on the expiry cycle completes normally.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) load_d_d = bus_rdata;
          state_d = DONE;
        end else if (expired) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          if (!bus_we_q) load_d_d = ERR_DATA;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (res) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      io_out_q    <= '0;
      load_d_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      io_out_q    <= io_out_d;
      load_d_q    <= load_d_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign io_out    = io_out_q;
  assign load_d    = load_d_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_io_unit.sv
// Self-checking bench for mem_io_unit: directed cases then random transactions vs. a transaction model.
module tb_mem_io_unit;

  localparam int unsigned TB_TIMEOUT  = 15;
  localparam logic [7:0]  TB_ERR_DATA = 8'hFF;
  localparam logic [3:0]  K_MEMIO     = 4'b0011;

  logic       ck;
  logic       res;
  logic       ck2;
  logic [3:0] kind;
  logic [1:0] fn2;
  logic [7:0] addr;
  logic [7:0] store_d;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] io_out;
  logic [7:0] load_d;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  // Architectural state as seen by the register file / sequencer.
  logic [7:0] exp_load_d;
  logic [7:0] exp_io_out;
  logic       exp_err;

  mem_io_unit #(
    .TIMEOUT  (TB_TIMEOUT),
    .ERR_DATA (TB_ERR_DATA)
  ) dut (
    .ck        (ck),
    .res       (res),
    .ck2       (ck2),
    .kind      (kind),
    .fn2       (fn2),
    .addr      (addr),
    .store_d   (store_d),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .io_out    (io_out),
    .load_d    (load_d),
    .busy      (busy),
    .err       (err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One bus transaction; ack_delay = ACCESS cycles before bus_ack is raised.
  task automatic do_mem(input logic [1:0] fn, input logic [7:0] a, input logic [7:0] d,
                        input int unsigned ack_delay, input logic [7:0] rdata);
    bit          timed_out;
    int unsigned n_access;
    timed_out = (ack_delay >= TB_TIMEOUT);
    n_access  = timed_out ? TB_TIMEOUT : ack_delay + 1;
    kind = K_MEMIO; ck2 = 1'b1; fn2 = fn; addr = a; store_d = d; bus_ack = 1'b0;
    tick();
    for (int unsigned i = 0; i < n_access; i++) begin
      chk("access_req", {7'd0, bus_req}, 8'd1);
      chk("access_busy", {7'd0, busy}, 8'd1);
      chk("access_we", {7'd0, bus_we}, {7'd0, fn[0]});
      chk("access_addr", bus_addr, a);
      chk("access_wdata", bus_wdata, d);
      chk("access_load_d", load_d, exp_load_d);
      fn2 = 2'($urandom); addr = 8'($urandom); store_d = 8'($urandom); ck2 = 1'($urandom);
      bus_ack   = (i == ack_delay);
      bus_rdata = (i == ack_delay) ? rdata : 8'($urandom);
      tick();
    end
    if (fn == 2'b00) exp_load_d = timed_out ? TB_ERR_DATA : rdata;
    if (timed_out) exp_err = 1'b1;
    // In DONE: offer a port-out launch that must be refused.
    bus_ack = 1'b0; bus_rdata = 8'($urandom);
    kind = K_MEMIO; ck2 = 1'b1; fn2 = 2'b10; store_d = 8'($urandom);
    chk("done_req", {7'd0, bus_req}, 8'd0);
    chk("done_busy", {7'd0, busy}, 8'd1);
    chk("done_load_d", load_d, exp_load_d);
    chk("done_err", {7'd0, err}, {7'd0, exp_err});
    tick();
    kind = 4'd0;
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_req", {7'd0, bus_req}, 8'd0);
    chk("idle_io_out", io_out, exp_io_out);
  endtask

  task automatic do_out(input logic [7:0] d);
    kind = K_MEMIO; ck2 = 1'b1; fn2 = 2'b10; store_d = d; bus_ack = 1'b0;
    tick();
    exp_io_out = d;
    kind = 4'd0;
    chk("out_io_out", io_out, exp_io_out);
    chk("out_busy", {7'd0, busy}, 8'd0);
    chk("out_req", {7'd0, bus_req}, 8'd0);
    chk("out_load_d", load_d, exp_load_d);
  endtask

  task automatic do_nolaunch(input string tag, input logic [3:0] k, input logic c2, input logic [1:0] fn);
    kind = k; ck2 = c2; fn2 = fn; addr = 8'($urandom); store_d = 8'($urandom); bus_ack = 1'b0;
    tick();
    kind = 4'd0;
    chk({tag, "_req"}, {7'd0, bus_req}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_io_out"}, io_out, exp_io_out);
    chk({tag, "_load_d"}, load_d, exp_load_d);
  endtask

  initial begin
    res = 1'b1; ck2 = 1'b0; kind = 4'd0; fn2 = 2'b11; addr = '0; store_d = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    exp_load_d = '0; exp_io_out = '0; exp_err = 1'b0;
    tick();
    tick();
    chk("rst_req", {7'd0, bus_req}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_load_d", load_d, 8'd0);
    chk("rst_io_out", io_out, 8'd0);
    chk("rst_addr", bus_addr, 8'd0);
    res = 1'b0;

    do_mem(2'b00, 8'h20, 8'h00, 2, 8'h5A);
    do_mem(2'b01, 8'h31, 8'hC3, 0, 8'h99);
    do_out(8'h7E);
    do_mem(2'b00, 8'h40, 8'h00, 100, 8'h12);
    do_mem(2'b00, 8'h41, 8'h00, 1, 8'h33);
    do_nolaunch("gate_ck2", K_MEMIO, 1'b0, 2'b10);
    do_nolaunch("gate_kind", 4'b0000, 1'b1, 2'b10);
    do_nolaunch("nop", K_MEMIO, 1'b1, 2'b11);

    // Reset during the third ACCESS cycle, then a stray late ack.
    kind = K_MEMIO; ck2 = 1'b1; fn2 = 2'b00; addr = 8'h66; bus_ack = 1'b0;
    tick();
    kind = 4'd0;
    tick();
    tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    exp_load_d = '0; exp_io_out = '0; exp_err = 1'b0;
    chk("midrst_req", {7'd0, bus_req}, 8'd0);
    chk("midrst_we", {7'd0, bus_we}, 8'd0);
    chk("midrst_addr", bus_addr, 8'd0);
    chk("midrst_wdata", bus_wdata, 8'd0);
    chk("midrst_io_out", io_out, 8'd0);
    chk("midrst_load_d", load_d, 8'd0);
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_err", {7'd0, err}, 8'd0);
    bus_ack = 1'b1; bus_rdata = 8'h77;
    tick();
    bus_ack = 1'b0;
    chk("lateack_load_d", load_d, 8'd0);
    chk("lateack_busy", {7'd0, busy}, 8'd0);
    chk("lateack_req", {7'd0, bus_req}, 8'd0);

    do_mem(2'b00, 8'h50, 8'h00, TB_TIMEOUT - 1, 8'hA5);
    do_mem(2'b01, 8'h51, 8'h3C, TB_TIMEOUT - 2, 8'h00);

    for (int n = 0; n < 30; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0: do_mem(2'b00, 8'($urandom), 8'($urandom), $urandom_range(0, 20), 8'($urandom));
        1: do_mem(2'b01, 8'($urandom), 8'($urandom), $urandom_range(0, 20), 8'($urandom));
        2: do_out(8'($urandom));
        default: do_nolaunch("rnd_nop", K_MEMIO, 1'b1, 2'b11);
      endcase
    end
    chk("final_err", {7'd0, err}, {7'd0, exp_err});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_unit.md
Name: mem_io_unit

Overview:
- Memory/IO access stage for the 8-bit pP core, directly beside the register file.
- Consumes the register file's store data and the ALU-computed address for mem_IO instructions (kind 4'b0011).
- Runs a handshaked access on the external data bus, or drives the output port.
- Returns load data (load_d) that the register file writes back during the ck2==0 phase; asserts busy to stall the sequencer while a bus access is outstanding.

Parameters:
- TIMEOUT, 15: maximum cycles to wait for bus_ack before aborting (1..255).
- ERR_DATA, 8'hFF: value placed on load_d when a load times out.

Ports:
- ck  input  1  system clock, all state on rising edge
- res  input  1  reset; one clock; reset is synchronous and active-high
- ck2  input  1  phase flag; 1 = execute phase (launch allowed), 0 = writeback phase
- kind  input  4  instruction kind; 4'b0011 = mem_IO
- fn2  input  2  00 load, 01 store, 10 port out, 11 no-op
- addr  input  8  effective address from ALU
- store_d  input  8  store/out data from register file
- bus_ack  input  1  external bus acknowledge
- bus_rdata  input  8  external read data, valid with bus_ack
- bus_req  output  1  bus request
- bus_we  output  1  1 = write cycle
- bus_addr  output  8  latched address
- bus_wdata  output  8  latched write data
- io_out  output  8  output port register
- load_d  output  8  load result to register file
- busy  output  1  stall request to sequencer
- err  output  1  sticky timeout flag

Behaviour:
- Reset (res=1 at rising ck) overrides everything, including an access in progress:
  - state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, io_out=0, load_d=0, busy=0, err=0, timeout counter=0.
  - An access abandoned by reset leaves no side effect; the bus must tolerate the dropped bus_req.
- launch = state==IDLE && kind==4'b0011 && ck2==1.
- States IDLE, ACCESS, DONE:
  - IDLE:
    - launch with fn2=00 or 01: latch addr into bus_addr and store_d into bus_wdata; bus_we=fn2[0]; bus_req=1; busy=1; counter=0; go to ACCESS next edge.
    - launch with fn2=10: io_out<=store_d in that same edge; stay IDLE; busy stays 0 (single cycle).
    - fn2=11: ignored.
  - ACCESS:
    - bus_req, bus_we, bus_addr and bus_wdata are held stable.
    - bus_ack=1 sampled: bus_req<=0; if load, load_d<=bus_rdata; go to DONE.
    - Otherwise counter increments. When counter==TIMEOUT-1 with no ack: bus_req<=0, err<=1, load_d<=ERR_DATA if load (store: nothing written), go to DONE.
    - Ack and timeout on the same edge: ack wins, err unchanged.
  - DONE: busy<=0, go to IDLE. Exactly one cycle; no launch is accepted in DONE.
- busy: registered; 1 from the edge after launch through the cycle spent in DONE's entry (i.e. busy=1 while state is ACCESS, cleared on leaving DONE).
- Latency:
  - load with ack on the first ACCESS cycle: load_d valid 2 edges after launch, busy high 2 cycles.
  - port out: 1 edge.
- load_d holds its value until the next completed load or timeout. Stores and port outs never change load_d.
- err is sticky and cleared only by res.
- kind/fn2/addr/store_d changes during ACCESS are ignored.
- No arithmetic beyond the counter, which is 8 bits and saturates (no wrap).

Decomposition:
- Shared package: KIND_MEMIO=4'b0011; FN_LOAD=2'b00, FN_STORE=2'b01, FN_OUT=2'b10, FN_NOP=2'b11; state encoding IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One natural sub-module, bus_timeout_ctr: clear, enable, expired output at TIMEOUT-1. All else stays in mem_io_unit.

Test Plan:
- Load, ack after 3 cycles: launch with fn2=00, addr=8'h20, bus_rdata=8'h5A → bus_req=1, bus_we=0, bus_addr=20; load_d=5A in DONE; busy high 4 cycles; err=0.
- Store, immediate ack: fn2=01, addr=8'h31, store_d=8'hC3 → bus_we=1, bus_wdata=C3 held until ack; load_d unchanged (5A).
- Port out: fn2=10, store_d=8'h7E, ck2=1 → io_out=7E after 1 edge; bus_req and busy never assert.
- Timeout, TIMEOUT=15, load, no ack → bus_req drops after 15 ACCESS cycles; load_d=FF; err=1. A following good load leaves err at 1.
- Reset mid-access: res=1 during ACCESS cycle 2 → next edge has state IDLE and all outputs 0. A late bus_ack after reset has no effect.
- Gating and priority:
  - ck2=0 with kind=0011 → no launch.
  - kind=0000 → no launch.
  - bus_ack arriving on the same edge as the timeout → load_d=bus_rdata, err=0.
